// File: rtl/approx_prefix_adder_pipe_pkg.sv
// Shared types and helpers for the pipelined approximate/exact prefix adder.
package approx_prefix_adder_pipe_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_APX_BITS = 8;
    localparam int DEF_CNT_W    = 16;
    localparam int STAGES       = 2;

    // Generate/propagate pair carried through the prefix network
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Prefix combine: hi covers the more significant span, lo the less significant one
    function automatic gp_t prefix_op(gp_t hi, gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    // Largest power of two strictly below n (1 for n <= 2); top level of the tree
    function automatic int top_pow2(int n);
        int d;
        d = 1;
        while (d * 2 < n) d = d * 2;
        return d;
    endfunction

endpackage

// File: rtl/approx_prefix_adder_pipe_bk_prefix_tree.sv
// Exact Brent-Kung carry tree over N bits with carry-in.
// c[i] is the carry out of bit i (into bit i+1); c[N-1] is the final carry.
module bk_prefix_tree
    import approx_prefix_adder_pipe_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] g,
    input  logic [N-1:0] p,
    input  logic         cin,
    output logic [N-1:0] c
);

    localparam int TOPD = top_pow2(N);

    gp_t [N-1:0] node;

    // Fold cin into bit 0, then up-sweep / down-sweep to get inclusive prefixes
    always_comb begin
        for (int i = 0; i < N; i++) begin
            node[i].g = g[i];
            node[i].p = p[i];
        end
        node[0].g = g[0] | (p[0] & cin);
        // up-sweep: node[k*2d+2d-1] absorbs the span of length d below it
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = 2 * d - 1; i < N; i = i + 2 * d) begin
                node[i] = prefix_op(node[i], node[i - d]);
            end
        end
        // down-sweep: fill the remaining positions from completed prefixes
        for (int d = TOPD; d >= 1; d = d / 2) begin
            for (int i = 3 * d - 1; i < N; i = i + 2 * d) begin
                node[i] = prefix_op(node[i], node[i - d]);
            end
        end
        for (int i = 0; i < N; i++) begin
            c[i] = node[i].g;
        end
    end

endmodule

// File: rtl/approx_prefix_adder_pipe.sv
// Pipelined adder: windowed approximate carry in the low APX_BITS bits, exact
// Brent-Kung carries above, exact reference for error flagging, saturating
// error counter. Two register stages with valid/ready flow control.
module approx_prefix_adder_pipe
    import approx_prefix_adder_pipe_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int APX_BITS = DEF_APX_BITS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             exact_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             approx_err,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int EXW = WIDTH - APX_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              advance;
    logic [STAGES:1]   vld_pipe;     // [1] = stage-1 valid, [2] = out_valid
    logic [WIDTH-1:0]  s1_a, s1_b;
    logic              s1_cin, s1_exact;

    // Whole pipe moves together; stalls only when the output is held
    assign advance   = !out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[2];

    // Stage 1: capture operands on advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[1] <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_cin      <= 1'b0;
            s1_exact    <= 1'b0;
        end else if (advance) begin
            vld_pipe[1] <= in_valid & advance;
            s1_a        <= a;
            s1_b        <= b;
            s1_cin      <= cin;
            s1_exact    <= exact_mode;
        end
    end

    logic [WIDTH-1:0] g, p;
    logic [WIDTH:0]   c_apx;         // carries into each bit of the approximate path
    logic [WIDTH-1:0] ref_co;        // exact carries out of each bit
    logic [WIDTH-1:0] apx_sum, ref_sum, res_sum;
    logic             apx_cout, ref_cout, res_cout, res_err;

    assign g        = s1_a & s1_b;
    assign p        = s1_a ^ s1_b;
    assign c_apx[0] = s1_cin;

    // Two-bit lookahead window: a carry only survives one propagate position
    for (genvar i = 0; i < APX_BITS; i++) begin : gen_win
        if (i == 0) begin : gen_lsb
            assign c_apx[1] = g[0] | (p[0] & s1_cin);
        end else begin : gen_mid
            assign c_apx[i+1] = g[i] | (p[i] & g[i-1]);
        end
    end

    // Exact upper region seeded by the (possibly wrong) boundary carry
    if (EXW > 0) begin : gen_hi
        bk_prefix_tree #(.N(EXW)) u_hi (
            .g   (g[WIDTH-1:APX_BITS]),
            .p   (p[WIDTH-1:APX_BITS]),
            .cin (c_apx[APX_BITS]),
            .c   (c_apx[WIDTH:APX_BITS+1])
        );
    end

    // Full-width exact reference, also serves exact_mode results
    bk_prefix_tree #(.N(WIDTH)) u_ref (
        .g   (g),
        .p   (p),
        .cin (s1_cin),
        .c   (ref_co)
    );

    assign apx_sum  = p ^ c_apx[WIDTH-1:0];
    assign apx_cout = c_apx[WIDTH];
    assign ref_sum  = p ^ {ref_co[WIDTH-2:0], s1_cin};
    assign ref_cout = ref_co[WIDTH-1];
    assign res_sum  = s1_exact ? ref_sum  : apx_sum;
    assign res_cout = s1_exact ? ref_cout : apx_cout;
    assign res_err  = !s1_exact && ({apx_cout, apx_sum} != {ref_cout, ref_sum});

    // Stage 2: result registers, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[2] <= 1'b0;
            sum         <= '0;
            cout        <= 1'b0;
            approx_err  <= 1'b0;
        end else if (advance) begin
            vld_pipe[2] <= vld_pipe[1];
            sum         <= res_sum;
            cout        <= res_cout;
            approx_err  <= res_err;
        end
    end

    // Saturating count of delivered erroneous results; clear wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_stats) begin
            err_cnt <= '0;
        end else if (out_valid && out_ready && approx_err && err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule
